fifo_read_sched: RTL

FIFO_READ_SCHED -- requirements
Module: fifo_read_sched

---
 rtl/fifo_read_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/fifo_read_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fifo_read_pkg.sv
// Shared state encoding and default constants for the fifo_read scheduler.
// The optional timeout supervisor is enabled with FIFO_READ_SCHED_TIMEOUT_EN.
package fifo_read_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARB     = 3'd1,
      S_START   = 3'd2,
      S_WAIT_FD = 3'd3,
      S_RELEASE = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6
   } sched_state_e;

   localparam logic [11:0] FRAME_NUM_DEF   = 12'd11;
   localparam int          TIMEOUT_CYC_DEF = 1023;
   localparam int          CNT_W           = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts at the channel after last_i and
// returns the first requesting channel as one-hot grant plus binary index.
module rr_arbiter #(
   parameter int N_CH = 4
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [2:0]      last_i,
   output logic [N_CH-1:0] grant_o,
   output logic [2:0]      idx_o
);

   logic [3:0]        last_p1;
   logic [3:0]        start;
   logic [3:0]        pos;
   logic [3:0]        ch_sum;
   logic [3:0]        ch;
   logic [2*N_CH-1:0] dbl;
   logic [N_CH-1:0]   rot;

   // Doubling the request vector turns the wrap-around search into a plain
   // lowest-set-bit search on a rotated copy.
   always_comb begin
      last_p1 = {1'b0, last_i} + 4'd1;
      start   = (last_p1 >= 4'(N_CH)) ? 4'd0 : last_p1;
      dbl     = {req_i, req_i} >> start;
      rot     = dbl[N_CH-1:0];
      pos     = 4'd0;
      for (int j = N_CH - 1; j >= 0; j--) begin
         if (rot[j]) pos = 4'(j);
      end
      ch_sum  = start + pos;
      ch      = (ch_sum >= 4'(N_CH)) ? (ch_sum - 4'(N_CH)) : ch_sum;
      grant_o = (|req_i) ? (N_CH'(1) << ch) : '0;
      idx_o   = ch[2:0];
   end

endmodule

// File: rtl/fifo_read_sched.sv
// Schedules N_CH channel FIFOs onto one fifo_read engine, one frame at a time.
// Define FIFO_READ_SCHED_TIMEOUT_EN to add the WAIT_FD timeout and sticky err.
module fifo_read_sched
   import fifo_read_pkg::*;
#(
   parameter int          N_CH        = 4,
   parameter logic [11:0] FRAME_NUM   = FRAME_NUM_DEF,
   parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] ch_req,
   output logic [N_CH-1:0] ch_grant,
   output logic [11:0]     fifo_num,
   output logic            fs,
   input  logic            fd,
   output logic            frame_valid,
   output logic [2:0]      frame_ch,
   input  logic            err_clr,
   output logic            err,
   output logic [3:0]      state_fs
);

   sched_state_e    state_q;
   logic [N_CH-1:0] grant_q;
   logic [2:0]      frame_ch_q;
   logic [2:0]      ptr_q;
   logic            fs_q;
   logic            frame_valid_q;

   logic [N_CH-1:0] arb_grant;
   logic [2:0]      arb_idx;

   rr_arbiter #(.N_CH(N_CH)) u_rr (
      .req_i   (ch_req),
      .last_i  (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

`ifdef FIFO_READ_SCHED_TIMEOUT_EN
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign cnt_d = cnt_q + 1'b1;
   assign err   = err_q;
`else
   logic [CNT_W:0] unused_cfg;

   assign unused_cfg = {err_clr, CNT_W'(TIMEOUT_CYC)};
   assign err        = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         grant_q       <= '0;
         frame_ch_q    <= '0;
         ptr_q         <= 3'(N_CH - 1);
         fs_q          <= 1'b0;
         frame_valid_q <= 1'b0;
`ifdef FIFO_READ_SCHED_TIMEOUT_EN
         err_q         <= 1'b0;
         cnt_q         <= '0;
`endif
      end else begin
         frame_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if ((|ch_req) && !err) state_q <= S_ARB;
            end
            S_ARB: begin
               // A request withdrawn between IDLE and ARB yields no grant.
               if (|arb_grant) begin
                  grant_q    <= arb_grant;
                  frame_ch_q <= arb_idx;
                  fs_q       <= 1'b1;
                  state_q    <= S_START;
               end else begin
                  state_q    <= S_IDLE;
               end
            end
            S_START: begin
               state_q <= S_WAIT_FD;
`ifdef FIFO_READ_SCHED_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_WAIT_FD: begin
               if (fd) begin
                  fs_q    <= 1'b0;
                  state_q <= S_RELEASE;
`ifdef FIFO_READ_SCHED_TIMEOUT_EN
               end else if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
                  // An err_clr in the same cycle defers the timeout by one cycle.
                  if (!err_clr) begin
                     fs_q    <= 1'b0;
                     grant_q <= '0;
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end else begin
                  cnt_q <= cnt_d;
`endif
               end
            end
            S_RELEASE: begin
               if (!fd) begin
                  frame_valid_q <= 1'b1;
                  grant_q       <= '0;
                  ptr_q         <= frame_ch_q;
                  state_q       <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
`ifdef FIFO_READ_SCHED_TIMEOUT_EN
            S_ERR: begin
               if (err_clr) begin
                  err_q   <= 1'b0;
                  ptr_q   <= frame_ch_q;
                  state_q <= S_IDLE;
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ch_grant    = grant_q;
   assign frame_ch    = frame_ch_q;
   assign fs          = fs_q;
   assign frame_valid = frame_valid_q;
   assign fifo_num    = FRAME_NUM;
   assign state_fs    = {1'b0, state_q};

endmodule
